// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared width, state/op encodings and constants for the mult/div engine
package multdiv_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_e;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_e;

    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/multdiv_iter_counter.sv
// rtl/multdiv_iter_counter.sv - load-on-start iteration counter, saturates at DATA_W-1
module multdiv_iter_counter #(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic clr,
    input  logic load_i,
    input  logic en_i,
    output logic last_iter_o
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [CW-1:0] count_q, count_d;

    // Holding at the last count keeps a finished operation from wrapping into another.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i && !last_iter_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_iter_o = (count_q == LAST);

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multicycle signed Booth multiplier / restoring divider
// Optional MULTDIV_EARLY_ZERO_EN: zero-operand cases complete one cycle after acceptance.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int DATA_W = multdiv_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ctrl_mult,
    input  logic              ctrl_div,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] result,
    output logic              exception,
    output logic              result_ready,
    output logic              busy
);

    localparam int W = DATA_W;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [W:0]    hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          qm1_q, qm1_d;
    logic [W:0]    m_q, m_d;
    logic          neg_q, neg_d;
    logic          dz_q, dz_d;
    logic          fin_q, fin_d;
    logic          early_q, early_d;
    logic [W-1:0]  result_q, result_d;
    logic          exc_q, exc_d;
    logic          cnt_load, cnt_en, last_iter;

    logic [W-1:0]  abs_a, abs_b, quot;
    logic [W:0]    booth_sum, div_shift, div_diff;
    logic [W:0]    prod_top;

    multdiv_iter_counter #(.DATA_W(W)) u_cnt (
        .clk         (clk),
        .clr         (clr),
        .load_i      (cnt_load),
        .en_i        (cnt_en),
        .last_iter_o (last_iter)
    );

    assign abs_a = data_a[W-1] ? -data_a : data_a;
    assign abs_b = data_b[W-1] ? -data_b : data_b;

    // hi is one bit wider than the operand so +/-INT_MIN never overflows before the shift.
    always_comb begin
        booth_sum = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   booth_sum = hi_q + m_q;
            2'b10:   booth_sum = hi_q - m_q;
            default: booth_sum = hi_q;
        endcase
    end

    assign div_shift = {hi_q[W-1:0], lo_q[W-1]};
    assign div_diff  = div_shift - m_q;
    assign quot      = neg_q ? -lo_q : lo_q;
    assign prod_top  = {hi_q[W-1:0], lo_q[W-1]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        fin_d    = fin_q;
        early_d  = early_q;
        result_d = result_q;
        exc_d    = exc_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            MULT, DIV: begin
                if (fin_q) begin
                    state_d = DONE;
                    if (op_q == OP_MULT) begin
                        result_d = lo_q;
                        exc_d    = !((&prod_top) || !(|prod_top));
                    end else begin
                        // A positive quotient with its MSB set can only be INT_MIN / -1.
                        result_d = dz_q ? '0 : quot;
                        exc_d    = dz_q || (!neg_q && lo_q[W-1]);
                    end
                end else begin
                    cnt_en = 1'b1;
                    fin_d  = last_iter;
                    if (op_q == OP_MULT) begin
                        hi_d  = {booth_sum[W], booth_sum[W:1]};
                        lo_d  = {booth_sum[0], lo_q[W-1:1]};
                        qm1_d = lo_q[0];
                    end else begin
                        hi_d = div_diff[W] ? div_shift : div_diff;
                        lo_d = {lo_q[W-2:0], !div_diff[W]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (early_q) begin
                    early_d  = 1'b0;
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = dz_q;
                end else if (ctrl_mult || ctrl_div) begin
                    cnt_load = 1'b1;
                    fin_d    = 1'b0;
                    hi_d     = '0;
                    qm1_d    = 1'b0;
                    if (ctrl_mult) begin
                        state_d = MULT;
                        op_d    = OP_MULT;
                        lo_d    = data_b;
                        m_d     = {data_a[W-1], data_a};
                    end else begin
                        state_d = DIV;
                        op_d    = OP_DIV;
                        lo_d    = abs_a;
                        m_d     = {1'b0, abs_b};
                        neg_d   = data_a[W-1] ^ data_b[W-1];
                        dz_d    = (data_b == '0);
                    end
`ifdef MULTDIV_EARLY_ZERO_EN
                    if (data_a == '0 || data_b == '0) begin
                        state_d = IDLE;
                        early_d = 1'b1;
                        dz_d    = !ctrl_mult && (data_b == '0);
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            fin_q    <= 1'b0;
            early_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            fin_q    <= fin_d;
            early_q  <= early_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign result       = result_q;
    assign exception    = exc_q;
    assign result_ready = (state_q == DONE);
    assign busy         = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed vectors against an arithmetic timeline model of multdiv_unit
`timescale 1ns/1ps
module tb_multdiv_unit;
    import multdiv_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 1;
`ifdef MULTDIV_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr, ctrl_mult, ctrl_div;
    logic [W-1:0] data_a, data_b, result;
    logic         exception, result_ready, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multdiv_unit #(.DATA_W(W)) dut (
        .clk          (clk),
        .clr          (clr),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .data_a       (data_a),
        .data_b       (data_b),
        .result       (result),
        .exception    (exception),
        .result_ready (result_ready),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_op(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output bit e);
        longint p;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[W-1:0];
            e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == '0) begin
            r = '0;
            e = 1'b1;
        end else if (a == INT_MIN && b == '1) begin
            r = INT_MIN;
            e = 1'b1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0;
        end
    endfunction

    // Timeline model: an accepted op completes LAT edges later (1 edge for early-zero cases).
    int           rem = 0;
    bit           m_early = 0, m_idle, chk_en = 0;
    logic [W-1:0] p_res, m_res = '0;
    bit           p_exc, m_exc = 0, m_ready = 0, m_busy = 0;

    always @(posedge clk) begin
        if (clr) begin
            rem = 0; m_early = 0; m_res = '0; m_exc = 0; m_ready = 0; m_busy = 0; chk_en = 1;
        end else begin
            m_idle  = (rem == 0);
            m_ready = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    m_ready = 1; m_res = p_res; m_exc = p_exc;
                end
            end
            if (m_idle && (ctrl_mult || ctrl_div)) begin
                model_op(ctrl_mult, data_a, data_b, p_res, p_exc);
                m_early = EARLY && (data_a == '0 || data_b == '0);
                rem = m_early ? 1 : LAT;
            end
            m_busy = (rem > 0) && !m_early;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", result_ready, m_ready);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_result", result, m_res);
            chk("cyc_exception", exception, m_exc);
        end
    end

    task automatic run_op(input string name, input bit is_mult, input bit both,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input bit exp_exc,
                          input int exp_lat, input int glitch_at);
        int lat, busy_cyc, hold_bad;
        logic [W-1:0] held;
        bit seen;
        held = result;
        ctrl_mult = is_mult || both;
        ctrl_div  = !is_mult || both;
        data_a = a;
        data_b = b;
        @(negedge clk);
        ctrl_mult = 0; ctrl_div = 0;
        data_a = ~a; data_b = b + 1;
        lat = 0; busy_cyc = 0; hold_bad = 0; seen = 0;
        while (lat <= 40) begin
            if (result_ready) begin
                seen = 1;
                break;
            end
            if (busy) busy_cyc++;
            if (result !== held) hold_bad++;
            if (lat == glitch_at) ctrl_div = 1;
            @(negedge clk);
            ctrl_div = 0;
            lat++;
        end
        chk($sformatf("%s ready_seen", name), seen, 1);
        if (seen) begin
            chk($sformatf("%s latency", name), lat, exp_lat);
            chk($sformatf("%s result", name), result, exp_res);
            chk($sformatf("%s exception", name), exception, exp_exc);
            chk($sformatf("%s model_result", name), m_res, exp_res);
            chk($sformatf("%s model_exc", name), m_exc, exp_exc);
            chk($sformatf("%s busy_cycles", name), busy_cyc, (exp_lat == LAT) ? LAT : 0);
            chk($sformatf("%s hold", name), hold_bad, 0);
        end
    endtask

    initial begin
        int rdy_cnt;
        clr = 1; ctrl_mult = 0; ctrl_div = 0; data_a = '0; data_b = '0;
        repeat (3) @(negedge clk);
        chk("reset result", result, 0);
        chk("reset exception", exception, 0);
        chk("reset ready", result_ready, 0);
        chk("reset busy", busy, 0);
        clr = 0;
        repeat (2) @(negedge clk);

        run_op("mul_7_m3",   1, 0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, LAT, -1);
        run_op("mul_ovf",    1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0,        1, LAT, -1);
        repeat (3) @(negedge clk);
        run_op("div_m17_5",  0, 0, 32'hFFFF_FFEF, 32'd5,        32'hFFFF_FFFD, 0, LAT, -1);
        run_op("div_9_0",    0, 0, 32'd9,        32'd0,        32'h0,        1, EARLY ? 1 : LAT, -1);
        run_op("div_min_m1", 0, 0, INT_MIN,      32'hFFFF_FFFF, 32'h8000_0000, 1, LAT, -1);
        run_op("div_100_m7", 0, 0, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, LAT, -1);
        run_op("div_min_1",  0, 0, INT_MIN,      32'd1,        32'h8000_0000, 0, LAT, -1);
        run_op("mul_min_min",1, 0, INT_MIN,      INT_MIN,      32'h0,        1, LAT, -1);
        run_op("mul_min_m1", 1, 0, INT_MIN,      32'hFFFF_FFFF, 32'h8000_0000, 1, LAT, -1);
        run_op("mul_m1_m1",  1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,        0, LAT, -1);
        run_op("mul_46340sq",1, 0, 32'd46340,    32'd46340,    32'h7FFE_A810, 0, LAT, -1);
        run_op("mul_46341sq",1, 0, 32'd46341,    32'd46341,    32'h8000_1219, 1, LAT, -1);
        run_op("div_20_3",   0, 0, 32'd20,       32'd3,        32'h6,        0, LAT, -1);
        run_op("b2b_mul_6_7",1, 0, 32'd6,        32'd7,        32'h2A,       0, LAT, -1);
        repeat (2) @(negedge clk);
        run_op("mul_glitch", 1, 0, 32'd123,      32'hFFFF_FFFE, 32'hFFFF_FF0A, 0, LAT, 10);
        repeat (2) @(negedge clk);
        run_op("both_starts",1, 1, 32'd20,       32'd3,        32'h3C,       0, LAT, -1);

        ctrl_div = 1; data_a = 32'd100; data_b = 32'd7;
        @(negedge clk);
        ctrl_div = 0;
        repeat (15) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("abort result", result, 0);
        chk("abort exception", exception, 0);
        chk("abort ready", result_ready, 0);
        chk("abort busy", busy, 0);
        rdy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (result_ready) rdy_cnt++;
        end
        chk("abort no_ready", rdy_cnt, 0);
        repeat (2) @(negedge clk);
        run_op("mul_after_clr", 1, 0, 32'd11,   32'd13,       32'd143,      0, LAT, -1);
        run_op("mul_zero",      1, 0, 32'd0,    32'd5,        32'h0,        0, EARLY ? 1 : LAT, -1);
        run_op("div_zero_a",    0, 0, 32'd0,    32'd5,        32'h0,        0, EARLY ? 1 : LAT, -1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
